// File: rtl/uart_loopback_tester.sv
`default_nettype none
// ============================================================================
// Module   : uart_loopback_tester
// Purpose  : Stop-and-wait UART loopback checker. Sends an LFSR byte pattern
//            through an external UART core and compares each echoed byte.
//            Mismatches, framing errors and timeouts are counted.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loopback_tester #(
    parameter int         NUM_BYTES      = 16,
    parameter logic [7:0] SEED           = 8'h01,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       is_transmitting,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] byte_index
);

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam int               TCW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [TCW-1:0]   TC_LAST  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_RX = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [7:0]     lfsr;
    logic [7:0]     lfsr_next;
    logic [TCW-1:0] tcnt;
    logic           start_ok;
    logic           send_now;
    logic           resolve;
    logic           byte_bad;
    logic           last_byte;

    // Next-state logic and the per-cycle decision strobes.
    always_comb begin
        state_next = state;
        lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        start_ok   = (state == IDLE) && start;
        send_now   = (state == SEND) && !is_transmitting;
        // A received pulse wins over a coincident timeout.
        resolve    = (state == WAIT_RX) && (received || (tcnt == TC_LAST));
        byte_bad   = received ? ((rx_byte != tx_byte) || recv_error) : 1'b1;
        last_byte  = (byte_index == LAST_IDX);
        case (state)
            IDLE:    if (start_ok) state_next = SEND;
            SEND:    if (send_now) state_next = WAIT_RX;
            WAIT_RX: if (resolve)  state_next = last_byte ? IDLE : SEND;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: pattern, strobe, timeout counter, result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED_EFF;
            transmit   <= 1'b0;
            tx_byte    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'h00;
            byte_index <= 8'h00;
            tcnt       <= '0;
        end else begin
            transmit <= 1'b0;
            if (start_ok) begin
                lfsr       <= SEED_EFF;
                byte_index <= 8'h00;
                err_count  <= 8'h00;
                done       <= 1'b0;
                pass       <= 1'b0;
                busy       <= 1'b1;
            end
            if (send_now) begin
                transmit <= 1'b1;
                tx_byte  <= lfsr;
                tcnt     <= '0;
            end
            // Counter stops at the resolve point, so it can never wrap.
            if ((state == WAIT_RX) && !resolve) begin
                tcnt <= tcnt + 1'b1;
            end
            if (resolve) begin
                if (byte_bad && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'h01;
                end
                if (last_byte) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 8'h00) && !byte_bad;
                end else begin
                    lfsr       <= lfsr_next;
                    byte_index <= byte_index + 8'h01;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_loopback_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loopback_tester
// Purpose  : Self-checking bench for uart_loopback_tester with an echoing
//            UART model, a transmit-byte scoreboard and scenario tasks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_loopback_tester;

    localparam int NB = 16;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT stimulus pieces
    logic       start      = 1'b0;
    logic       tx_hold    = 1'b0;
    logic       model_busy = 1'b0;
    logic       echo_rcv   = 1'b0;
    logic       stray_rcv  = 1'b0;
    logic       recv_err   = 1'b0;
    logic [7:0] echo_byte  = 8'h00;
    logic [7:0] stray_byte = 8'h00;
    logic       is_tx;
    logic       rcv;
    logic [7:0] rxb;
    assign is_tx = model_busy | tx_hold;
    assign rcv   = echo_rcv | stray_rcv;
    assign rxb   = stray_rcv ? stray_byte : echo_byte;

    logic       transmit, busy, done, pass;
    logic [7:0] tx_byte, err_count, byte_index;

    uart_loopback_tester #(.NUM_BYTES(NB), .SEED(8'h01), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .transmit(transmit), .tx_byte(tx_byte),
        .is_transmitting(is_tx), .received(rcv), .rx_byte(rxb), .recv_error(recv_err),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .byte_index(byte_index)
    );

    // Small DUT: no echo ever, zero seed (replaced by 01)
    logic       start_s = 1'b0;
    logic       tx_s, busy_s, done_s, pass_s;
    logic [7:0] txb_s, err_s, idx_s;

    uart_loopback_tester #(.NUM_BYTES(4), .SEED(8'h00), .TIMEOUT_CYCLES(100)) dut_s (
        .clk(clk), .rst(rst), .start(start_s),
        .transmit(tx_s), .tx_byte(txb_s),
        .is_transmitting(1'b0), .received(1'b0), .rx_byte(8'h00), .recv_error(1'b0),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .byte_index(idx_s)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         tx_pulses = 0;
    int         echo_mode = 0;   // 0 ideal, 1 flip bit0 of idx3, 2 none, 3 recv_error on idx1
    logic [7:0] exp_q[$];
    logic [7:0] seen[$];

    function automatic logic [7:0] lfsr_step(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    // Scoreboard: every transmit pulse pops the next expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1) begin
                tx_pulses++;
                seen.push_back(tx_byte);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_tx_byte: unexpected transmit got=%02h expected none", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_byte !== e) begin
                        failures++;
                        $display("FAIL sb_tx_byte: got=%02h expected=%02h", tx_byte, e);
                    end
                end
            end
        end
    end

    // UART model: busy for 3 cycles after a transmit, then echoes the byte.
    initial begin
        logic [7:0] b;
        logic [7:0] i;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1 && !rst) begin
                b = tx_byte;
                i = byte_index;
                model_busy = 1'b1;
                repeat (3) @(negedge clk);
                model_busy = 1'b0;
                if (echo_mode != 2) begin
                    @(negedge clk);
                    echo_byte = (echo_mode == 1 && i == 8'd3) ? (b ^ 8'h01) : b;
                    recv_err  = (echo_mode == 3 && i == 8'd1);
                    echo_rcv  = 1'b1;
                    @(negedge clk);
                    echo_rcv  = 1'b0;
                    recv_err  = 1'b0;
                end
            end
        end
    end

    task automatic begin_run();
        logic [7:0] m;
        exp_q.delete();
        seen.delete();
        tx_pulses = 0;
        m = 8'h01;
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(m);
            m = lfsr_step(m);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done got=%b expected=1 within 5000 cycles", name, done);
        end
    endtask

    task automatic check_run(input string name, input logic [7:0] e_err, input logic e_pass);
        checks++;
        if (pass !== e_pass) begin
            failures++;
            $display("FAIL %s_pass: got=%b expected=%b", name, pass, e_pass);
        end
        checks++;
        if (err_count !== e_err) begin
            failures++;
            $display("FAIL %s_err_count: got=%0d expected=%0d", name, err_count, e_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: got=%b expected=0", name, busy);
        end
        checks++;
        if (tx_pulses != NB) begin
            failures++;
            $display("FAIL %s_pulses: got=%0d expected=%0d", name, tx_pulses, NB);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({transmit, tx_byte, busy, done, pass, err_count, byte_index} !== 27'd0) begin
            failures++;
            $display("FAIL reset_main: got=%07h expected=0",
                     {transmit, tx_byte, busy, done, pass, err_count, byte_index});
        end
        checks++;
        if ({tx_s, txb_s, busy_s, done_s, pass_s, err_s, idx_s} !== 27'd0) begin
            failures++;
            $display("FAIL reset_small: got=%07h expected=0",
                     {tx_s, txb_s, busy_s, done_s, pass_s, err_s, idx_s});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ideal();
        logic [7:0] first5 [5];
        first5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        echo_mode = 0;
        begin_run();
        wait_done("ideal");
        check_run("ideal", 8'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (seen.size() <= k || seen[k] !== first5[k]) begin
                failures++;
                $display("FAIL ideal_seq%0d: got=%02h expected=%02h", k,
                         (seen.size() > k) ? seen[k] : 8'hxx, first5[k]);
            end
        end
    endtask

    task automatic test_mismatch();
        echo_mode = 1;
        begin_run();
        wait_done("mismatch");
        check_run("mismatch", 8'd1, 1'b0);
        echo_mode = 0;
    endtask

    task automatic test_recv_error();
        echo_mode = 3;
        begin_run();
        wait_done("recv_error");
        check_run("recv_error", 8'd1, 1'b0);
        echo_mode = 0;
    endtask

    task automatic test_busy_start_stray();
        int  cyc;
        logic hit;
        echo_mode = 0;
        begin_run();
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (echo_rcv && byte_index == 8'd2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL stray_reach_idx2: got=timeout expected=echo of byte 2");
        end
        tx_hold = 1'b1;
        @(negedge clk);
        stray_byte = 8'hFF;
        stray_rcv  = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        stray_rcv  = 1'b0;
        start      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (byte_index !== 8'd3 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL stray_ignored: idx=%0d err=%0d expected idx=3 err=0", byte_index, err_count);
        end
        tx_hold = 1'b0;
        wait_done("stray");
        check_run("stray", 8'd0, 1'b1);
    endtask

    task automatic test_tx_hold();
        int  early;
        int  cyc;
        echo_mode = 0;
        tx_hold   = 1'b1;
        begin_run();
        early = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (transmit !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL hold_no_transmit: got=%0d pulses expected=0", early);
        end
        tx_hold = 1'b0;
        cyc = 0;
        while (transmit !== 1'b1 && cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (transmit !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_pulse: got=%b expected=1 within 3 cycles", transmit);
        end
        wait_done("hold");
        check_run("hold", 8'd0, 1'b1);
    endtask

    task automatic test_reset_midrun();
        int  cyc;
        echo_mode = 0;
        begin_run();
        cyc = 0;
        while (byte_index !== 8'd5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (byte_index !== 8'd5) begin
            failures++;
            $display("FAIL midrun_reach_idx5: got=%0d expected=5", byte_index);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({transmit, tx_byte, busy, done, pass, err_count, byte_index} !== 27'd0) begin
            failures++;
            $display("FAIL midrun_reset_vals: got=%07h expected=0",
                     {transmit, tx_byte, busy, done, pass, err_count, byte_index});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({transmit, tx_byte, busy, done, pass, err_count, byte_index} !== 27'd0) begin
            failures++;
            $display("FAIL midrun_reset_hold: got=%07h expected=0",
                     {transmit, tx_byte, busy, done, pass, err_count, byte_index});
        end
        rst = 1'b0;
        exp_q.delete();
        tx_pulses = 0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_pulses != 0) begin
            failures++;
            $display("FAIL midrun_no_restart: busy=%b pulses=%0d expected busy=0 pulses=0", busy, tx_pulses);
        end
        begin_run();
        wait_done("midrun");
        check_run("midrun", 8'd0, 1'b1);
    endtask

    task automatic test_no_echo();
        int  cyc;
        int  n;
        int  t_prev;
        logic fin;
        logic [7:0] m;
        m = 8'h01;
        n = 0;
        t_prev = 0;
        fin = 1'b0;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (tx_s === 1'b1) begin
                checks++;
                if (txb_s !== m) begin
                    failures++;
                    $display("FAIL noecho_byte%0d: got=%02h expected=%02h", n, txb_s, m);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - t_prev != 101) begin
                        failures++;
                        $display("FAIL noecho_spacing%0d: got=%0d expected=101", n, cyc - t_prev);
                    end
                end
                t_prev = cyc;
                n++;
                m = lfsr_step(m);
            end
            if (done_s === 1'b1) begin
                fin = 1'b1;
                checks++;
                if (cyc - t_prev != 100) begin
                    failures++;
                    $display("FAIL noecho_last_latency: got=%0d expected=100", cyc - t_prev);
                end
            end
        end
        checks++;
        if (!fin || n != 4) begin
            failures++;
            $display("FAIL noecho_finish: done=%b pulses=%0d expected done=1 pulses=4", fin, n);
        end
        checks++;
        if (err_s !== 8'd4 || pass_s !== 1'b0 || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL noecho_result: err=%0d pass=%b busy=%b expected err=4 pass=0 busy=0",
                     err_s, pass_s, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_mismatch();
        test_recv_error();
        test_busy_start_stray();
        test_tx_hold();
        test_reset_midrun();
        test_no_echo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
